// File: rtl/fetch_sequencer_if.sv
// Bundles the fetch sequencer's memory, decoder and redirect signals.
// master: the sequencer side (drives mem_req/mem_addr, the instruction buffer, fault and count).
// slave:  the environment side (memory, decoder, execute redirect).
interface fetch_sequencer_if;
  // instruction memory request/acknowledge
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // decoder valid/ready
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  // execute redirect
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // status
  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc,
    output fetch_fault, fetch_count
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc,
    input  fetch_fault, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, single-outstanding memory fetch, one-entry decoder buffer.
// Latency: word visible one cycle after mem_ack; accept -> next request one cycle later (1 instr / 2 cycles peak).
// Backpressure: instr_ready=0 holds the buffer and stalls fetching; redirects discard in-flight/buffered data.
// Ports: clk, rst_n (synchronous, active-low), bus (fetch_sequencer_if.master): memory req/ack,
//   decoder valid/ready, redirect from execute, sticky fetch_fault and fetch_count. All outputs registered.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_RST, S_REQ, S_HOLD, S_FAULT} state_t;

  state_t      state_q, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] req_addr_q, req_addr_nxt;
  logic        kill_q, kill_nxt;
  logic [31:0] buf_data_q, buf_data_nxt;
  logic [31:0] buf_pc_q, buf_pc_nxt;
  logic [31:0] count_q, count_nxt;
  logic        fault_q, fault_nxt;
  logic        mem_req_q;
  logic        instr_valid_q;
  logic        redir_bad;

  assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_nxt    = state_q;
    pc_nxt       = pc_q;
    req_addr_nxt = req_addr_q;
    kill_nxt     = kill_q;
    buf_data_nxt = buf_data_q;
    buf_pc_nxt   = buf_pc_q;
    count_nxt    = count_q;
    fault_nxt    = fault_q;

    case (state_q)
      S_RST: begin
        state_nxt = S_REQ;
      end

      S_REQ: begin
        if (redir_bad) begin
          state_nxt = S_FAULT;
          fault_nxt = 1'b1;
        end else if (bus.mem_ack) begin
          if (bus.redirect_valid) begin
            // returning word is wrong-path; restart straight at the target
            kill_nxt     = 1'b0;
            pc_nxt       = bus.redirect_pc;
            req_addr_nxt = bus.redirect_pc;
          end else if (kill_q) begin
            // redirect arrived while waiting: drop this word, fetch the saved target
            kill_nxt     = 1'b0;
            req_addr_nxt = pc_q;
          end else begin
            buf_data_nxt = bus.mem_rdata;
            buf_pc_nxt   = req_addr_q;
            pc_nxt       = req_addr_q + 32'd4;
            state_nxt    = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          // mem_addr must stay stable until ack, so only remember the target
          kill_nxt = 1'b1;
          pc_nxt   = bus.redirect_pc;
        end
      end

      S_HOLD: begin
        if (redir_bad) begin
          state_nxt = S_FAULT;
          fault_nxt = 1'b1;
        end else if (bus.redirect_valid) begin
          // redirect wins over ready: buffered word is never counted
          pc_nxt       = bus.redirect_pc;
          req_addr_nxt = bus.redirect_pc;
          state_nxt    = S_REQ;
        end else if (bus.instr_ready) begin
          count_nxt    = count_q + 32'd1;
          req_addr_nxt = pc_q;
          state_nxt    = S_REQ;
        end
      end

      S_FAULT: begin
        state_nxt = S_FAULT;
      end

      default: begin
        state_nxt = S_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_RST;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      kill_q        <= 1'b0;
      buf_data_q    <= 32'd0;
      buf_pc_q      <= 32'd0;
      count_q       <= 32'd0;
      fault_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      pc_q          <= pc_nxt;
      req_addr_q    <= req_addr_nxt;
      kill_q        <= kill_nxt;
      buf_data_q    <= buf_data_nxt;
      buf_pc_q      <= buf_pc_nxt;
      count_q       <= count_nxt;
      fault_q       <= fault_nxt;
      // handshake outputs registered from the next state so no input reaches an output combinationally
      mem_req_q     <= (state_nxt == S_REQ);
      instr_valid_q <= (state_nxt == S_HOLD);
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = req_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_data  = buf_data_q;
  assign bus.instr_pc    = buf_pc_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fetch_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the priRV32 core. It owns the program counter and runs a single-outstanding request/acknowledge handshake to instruction memory. It holds each fetched word in a one-entry buffer and presents it to the decoder with a valid/ready handshake. It also applies PC redirects from execute (jal/jalr/taken branches), discarding any wrong-path data in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  fetch address; stable while mem_req=1 and mem_ack=0
- mem_ack  in  1  memory response; mem_rdata valid in the same cycle; ignored when mem_req=0
- mem_rdata  in  32  fetched instruction word
- instr_valid  out  1  buffered instruction available to decoder
- instr_data  out  32  buffered instruction word
- instr_pc  out  32  address of instr_data
- instr_ready  in  1  decoder accepts instr_data this cycle when instr_valid=1
- redirect_valid  in  1  execute requests PC change
- redirect_pc  in  32  new PC, sampled when redirect_valid=1
- fetch_fault  out  1  sticky misaligned-redirect flag
- fetch_count  out  32  number of instructions accepted by the decoder

## Operation
- States: RST, REQ, HOLD, FAULT. Encoding is free.
- Registers: pc (next fetch address), req_addr (drives mem_addr), kill (discard flag), buffer (instr_data, instr_pc), fetch_count.
- RST: entered while rst_n=0. Sets pc=req_addr=RESET_PC, kill=0, count=0, all outputs 0. Unconditionally goes to REQ on the first cycle with rst_n=1.
- REQ: mem_req=1, mem_addr=req_addr.
  - ack and kill=0 and no redirect: capture buffer <- (mem_rdata, req_addr), pc <- req_addr+4, go to HOLD.
  - ack and kill=1, no redirect: discard data, kill <- 0, req_addr <- pc, stay in REQ.
  - ack and redirect (either kill value): discard data, kill <- 0, req_addr <- pc <- redirect_pc, stay in REQ.
  - no ack and redirect: kill <- 1, pc <- redirect_pc; req_addr holds. If several redirects arrive, the latest wins.
- HOLD: instr_valid=1, mem_req=0.
  - redirect (priority over ready): buffer dropped, no count increment, req_addr <- pc <- redirect_pc, go to REQ.
  - ready and no redirect: fetch_count += 1, req_addr <- pc, go to REQ.
- Misaligned redirect (redirect_pc[1:0] != 0) in any state: go to FAULT, fetch_fault <- 1, no count increment.
- FAULT: mem_req=0, instr_valid=0. Exit only through reset.
- Arithmetic: pc+4 and fetch_count wrap modulo 2^32; no overflow flag.
- rst_n=0 mid-transaction: abandons any outstanding request; mem_req=0 on the following cycle. Memory must tolerate a dropped request.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, fetch_fault=0, fetch_count=0.
- rst_n rises before edge E0 -> mem_req=1 with mem_addr=RESET_PC from E0 onward.
- mem_ack at edge N -> instr_valid=1 after N; the word is visible one cycle after ack.
- Accept (valid & ready) at edge M -> mem_req=1 with the next address after M. Peak throughput is one instruction per 2 cycles with zero-wait memory.
- Redirect at edge R while in HOLD -> instr_valid=0 and mem_addr=redirect_pc after R.
- Redirect at edge R while in REQ without ack -> mem_addr unchanged until ack. The cycle after that ack, mem_addr=redirect_pc.
- All outputs are driven from registers. No combinational path from inputs to outputs.

## Test plan
- Reset and stream: RESET_PC=0, memory always acks with data=addr^32'hA5A5_A5A5, ready always 1 -> decoder receives pc 0,4,8,12 with matching data; fetch_count=4 after the 4th accept.
- Decoder backpressure: ready=0 for 5 cycles in HOLD -> instr_valid, instr_data and instr_pc stable; mem_req=0 throughout; count unchanged.
- Redirect during wait state: mem_ack delayed 3 cycles on addr 0x10, redirect to 0x200 in wait cycle 1 -> mem_addr stays 0x10 until ack, that data is never valid, next mem_addr=0x200, first instr_pc=0x200.
- Redirect with simultaneous ack or ready: redirect to 0x80 coincident with ack, and separately coincident with ready in HOLD -> no instruction from the old path is accepted, count unchanged, next fetch at 0x80.
- Misaligned redirect: redirect_pc=0x102 -> fetch_fault=1, mem_req=0 and instr_valid=0 forever; rst_n=0 for one cycle clears the fault and fetch restarts at RESET_PC.
- Reset mid-request and wrap: assert rst_n=0 while mem_req=1 -> all outputs return to reset values next cycle. Redirect to 0xFFFF_FFFC -> following fetch address 0x0000_0000.
